// File: rtl/systolic_result_drain_if.sv
// Memory write port of the systolic result drain.
//   master : driven by the drain (mem_write, mem_data_write, act_addr), samples mem_grant
//   slave  : memory side, drives mem_grant
// A word transfers on a rising clock edge where mem_write and mem_grant are both high.
interface systolic_result_drain_if #(
  parameter int WIDTH = 16
);
  logic                    mem_grant;
  logic                    mem_write;
  logic signed [WIDTH-1:0] mem_data_write;
  logic [11:0]             act_addr;

  modport master (
    input  mem_grant,
    output mem_write,
    output mem_data_write,
    output act_addr
  );

  modport slave (
    output mem_grant,
    input  mem_write,
    input  mem_data_write,
    input  act_addr
  );
endinterface

// File: rtl/systolic_result_drain.sv
// Systolic result drain: captures the skewed column outputs of an N x N systolic
// array into a tile buffer, then writes the tile row-major to memory through a
// grant handshake.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : pulse, result_col[0] carries C[0][0] in this cycle
//   result_col  : per-column skewed array outputs (N words of WIDTH bits)
//   addr_C, n   : tile base address and requested dimension, latched on start
//   mem         : memory write port (master side)
//   busy        : high while capturing or draining
//   done        : one-cycle completion pulse
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; the start cycle already captures slot c=0
// CAPTURE | capturing skew slots c=1 .. 2*n_eff-2, one per cycle, no stall
// DRAIN   | presenting word k, advancing on mem_write & mem_grant
// DONE    | done pulse for one cycle, then back to IDLE
module systolic_result_drain #(
  parameter int N     = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [N-1:0][WIDTH-1:0]    result_col,
  input  logic [11:0]                addr_C,
  input  logic [3:0]                 n,
  systolic_result_drain_if.master    mem,
  output logic                       busy,
  output logic                       done
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (N > 1) ? $clog2(N * N) : 1;
  // n is only 4 bits wide, so the effective dimension can never exceed 15.
  localparam logic [3:0] N_CAP = (N > 15) ? 4'd15 : 4'(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [3:0]    n_eff_in;
  logic [3:0]    n_eff_r;
  logic [3:0]    n_eff_cap;
  logic [11:0]   base_r;
  logic [4:0]    c_r;
  logic [4:0]    cap_idx;
  logic [KW-1:0] k_r;
  logic [RW-1:0] row_r;
  logic [RW-1:0] col_r;
  logic          accept;
  logic          cap_en;
  logic          cap_last;
  logic          k_last;
  logic          wr_accept;
  logic [N-1:0]  col_we;
  logic [RW-1:0] col_row [N];

  logic signed [WIDTH-1:0] tile_buf [N][N];

  assign n_eff_in  = (n > N_CAP) ? N_CAP : n;
  assign accept    = (state == S_IDLE) && start;
  assign cap_last  = (c_r == (({1'b0, n_eff_r}) << 1) - 5'd2);
  assign k_last    = (32'(k_r) == (32'(n_eff_r) * 32'(n_eff_r)) - 32'd1);
  assign wr_accept = (state == S_DRAIN) && mem.mem_grant;

  // The start cycle captures slot 0 from the live inputs before anything is latched.
  assign cap_en    = accept || (state == S_CAPTURE);
  assign cap_idx   = (state == S_IDLE) ? 5'd0 : c_r;
  assign n_eff_cap = (state == S_IDLE) ? n_eff_in : n_eff_r;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (n_eff_in == 4'd0)      state_nxt = S_DONE;
          else if (n_eff_in == 4'd1) state_nxt = S_DRAIN;
          else                       state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: if (cap_last) state_nxt = S_DRAIN;
      S_DRAIN:   if (wr_accept && k_last) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem.mem_write      = 1'b0;
    mem.mem_data_write = '0;
    mem.act_addr       = '0;
    busy               = 1'b0;
    done               = 1'b0;
    case (state)
      S_CAPTURE: busy = 1'b1;
      S_DRAIN: begin
        busy               = 1'b1;
        mem.mem_write      = 1'b1;
        mem.mem_data_write = tile_buf[row_r][col_r];
        mem.act_addr       = base_r + 12'(k_r);
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Counters and latched tile parameters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r  <= '0;
      n_eff_r <= '0;
      c_r     <= '0;
      k_r     <= '0;
      row_r   <= '0;
      col_r   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_r  <= addr_C;
            n_eff_r <= n_eff_in;
            c_r     <= 5'd1;
            k_r     <= '0;
            row_r   <= '0;
            col_r   <= '0;
          end
        end
        S_CAPTURE: c_r <= c_r + 5'd1;
        S_DRAIN: begin
          if (wr_accept) begin
            k_r <= k_r + 1'b1;
            if (col_r == RW'(n_eff_r - 4'd1)) begin
              col_r <= '0;
              row_r <= row_r + 1'b1;
            end else begin
              col_r <= col_r + 1'b1;
            end
          end
        end
        S_DONE: begin
          c_r <= '0;
          k_r <= '0;
        end
        default: ;
      endcase
    end
  end

  // De-skew: at slot c, column j holds element [c-j][j] while 0 <= c-j < n_eff.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      col_we[j]  = cap_en && (32'(cap_idx) >= 32'(j)) &&
                   ((32'(cap_idx) - 32'(j)) < 32'(n_eff_cap));
      col_row[j] = RW'(32'(cap_idx) - 32'(j));
    end
  end

  // Tile buffer carries no reset; an abandoned tile is simply overwritten.
  always_ff @(posedge clk) begin
    for (int j = 0; j < N; j++) begin
      if (col_we[j]) tile_buf[col_row[j]][j] <= result_col[j];
    end
  end

endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 The block SHALL have parameter N, default 4, the systolic array dimension (columns of result_col).
REQ-002 The block SHALL have parameter WIDTH, default 16, the signed data word width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset: asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, pulse marking the cycle in which result_col[0] carries C[0][0].
REQ-006 The block SHALL have port result_col, input, N x WIDTH signed, per-column skewed array outputs.
REQ-007 The block SHALL have port addr_C, input, 12, base address of the result matrix.
REQ-008 The block SHALL have port n, input, 4, active matrix dimension.
REQ-009 The block SHALL have port mem_grant, input, 1, memory accepts the presented write this cycle.
REQ-010 The block SHALL have port mem_write, output, 1, write request.
REQ-011 The block SHALL have port mem_data_write, output, WIDTH signed, write data.
REQ-012 The block SHALL have port act_addr, output, 12, write address.
REQ-013 The block SHALL have port busy, output, 1, high in CAPTURE and DRAIN.
REQ-014 The block SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-015 States SHALL be IDLE, CAPTURE, DRAIN, DONE.
REQ-016 In IDLE, start high SHALL latch addr_C and n, set capture counter c=0, capture the c=0 slot, and move to CAPTURE (to DRAIN if n_eff=1, to DONE if n=0).
REQ-017 Effective dimension SHALL be n_eff = min(n, N); n=0 SHALL produce no writes and reach DONE in one cycle.
REQ-018 Skew rule: at capture count c, column j SHALL store result_col[j] into buffer element [c-j][j] iff 0 <= c-j < n_eff; other columns ignored.
REQ-019 CAPTURE SHALL increment c each cycle and exit to DRAIN after capturing c = 2*n_eff-2; capture SHALL never stall.
REQ-020 DRAIN SHALL present words row-major, index k=i*n_eff+j, with mem_write=1, mem_data_write=buf[i][j], act_addr=(addr_C + k) mod 4096.
REQ-021 k SHALL advance only on a cycle where mem_write and mem_grant are both high; while mem_grant is low, mem_write, data and address SHALL hold stable.
REQ-022 After the grant of k = n_eff*n_eff-1, the block SHALL enter DONE; DONE SHALL assert done for exactly one cycle, with mem_write=0, then return to IDLE.
REQ-023 start SHALL be ignored in CAPTURE, DRAIN and DONE; latched addr_C and n SHALL not change until the next accepted start.
REQ-024 Data SHALL be stored and written bit-exact (signed, no saturation or truncation).
REQ-025 mem_write SHALL be 0 in IDLE, CAPTURE and DONE.

Reset
REQ-026 rst high SHALL immediately force IDLE, mem_write=0, mem_data_write=0, act_addr=0, busy=0, done=0, c=0, k=0, regardless of state.
REQ-027 Reset mid-CAPTURE or mid-DRAIN SHALL abandon the tile with no further writes; buffer contents need not be cleared.
REQ-028 After rst deasserts, the first accepted start SHALL behave exactly as in REQ-016.

Verification
REQ-029 n=4, addr_C=0x100, C[i][j]=16*i+j fed skewed, mem_grant=1 -> 7 capture cycles, then 16 consecutive writes 0x100..0x10F with data 0..3,16..19,32..35,48..51, then done pulse.
REQ-030 n=2, mem_grant toggling 1,0,0,1,... -> each word held stable through low-grant cycles; exactly 4 writes, addresses addr_C..addr_C+3, no duplicates.
REQ-031 n=0 with start -> no mem_write, done pulses the cycle after start; n=9 with N=4 -> behaves as n=4.
REQ-032 addr_C=0xFFE, n=2 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-033 rst asserted after 5 DRAIN writes -> mem_write drops without waiting for clk edge; no further writes; new start after release drains a fresh tile correctly.
REQ-034 start pulsed again during CAPTURE and DRAIN with different addr_C -> ignored; all writes use the original base.
